// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - memory-message types, responder states and size helpers
package bp_me_pkg;

  typedef enum logic [0:0] {e_bp_inv_cfg = 1'b0} bp_params_e;

  typedef struct packed {
    int paddr_width;
    int dword_width;
    int cce_block_width;
    int lce_id_width;
    int lce_max_assoc;
  } bp_cfg_s;

  localparam int paddr_width_gp     = 40;
  localparam int dword_width_gp     = 64;
  localparam int cce_block_width_gp = 512;
  localparam int lce_id_width_gp    = 4;
  localparam int lce_max_assoc_gp   = 8;
  localparam int way_id_width_gp    = $clog2(lce_max_assoc_gp);

  function automatic bp_cfg_s bp_get_cfg(input bp_params_e cfg);
    bp_cfg_s c;
    case (cfg)
      default: c = '{paddr_width: paddr_width_gp, dword_width: dword_width_gp,
                     cce_block_width: cce_block_width_gp, lce_id_width: lce_id_width_gp,
                     lce_max_assoc: lce_max_assoc_gp};
    endcase
    return c;
  endfunction

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3,
    e_cce_mem_pre   = 4'd4
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [2:0] {
    e_mem_size_1  = 3'd0,
    e_mem_size_2  = 3'd1,
    e_mem_size_4  = 3'd2,
    e_mem_size_8  = 3'd3,
    e_mem_size_16 = 3'd4,
    e_mem_size_32 = 3'd5,
    e_mem_size_64 = 3'd6
  } bp_mem_size_e;

  typedef struct packed {
    logic [way_id_width_gp-1:0] way_id;
    logic [lce_id_width_gp-1:0] lce_id;
  } bp_cce_mem_payload_s;

  typedef struct packed {
    bp_cce_mem_payload_s        payload;
    bp_mem_size_e               size;
    logic [paddr_width_gp-1:0]  addr;
    bp_cce_mem_cmd_type_e       msg_type;
  } bp_cce_mem_msg_header_s;

  typedef struct packed {
    logic [cce_block_width_gp-1:0] data;
    bp_cce_mem_msg_header_s        header;
  } bp_cce_mem_msg_s;

  typedef enum logic [1:0] {
    e_ready    = 2'd0,
    e_dev_req  = 2'd1,
    e_dev_wait = 2'd2,
    e_resp     = 2'd3
  } bp_io_responder_state_e;

  // A dword port cannot serve wider requests, so anything above 8 bytes is treated as 8.
  function automatic logic [3:0] bp_mem_size_to_bytes(input bp_mem_size_e size);
    case (size)
      e_mem_size_1: return 4'd1;
      e_mem_size_2: return 4'd2;
      e_mem_size_4: return 4'd4;
      default:      return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/bp_io_lane_align.sv
// rtl/bp_io_lane_align.sv - byte-lane mask, write shift and read extraction for one dword
module bp_io_lane_align
  import bp_me_pkg::*;
#(
  parameter int cce_block_width_p = cce_block_width_gp
) (
  input  bp_mem_size_e                  size_i,
  input  logic [2:0]                    offset_i,
  input  logic [dword_width_gp-1:0]     wdata_i,
  input  logic [dword_width_gp-1:0]     rdata_i,
  output logic [dword_width_gp/8-1:0]   mask_o,
  output logic [dword_width_gp-1:0]     wdata_o,
  output logic [cce_block_width_p-1:0]  rdata_o
);

  logic [3:0]                bytes;
  logic [2:0]                offset;
  logic [7:0]                byte_ones;
  logic [dword_width_gp-1:0] byte_sel;
  logic [dword_width_gp-1:0] rdata_shift;

  always_comb begin
    bytes     = bp_mem_size_to_bytes(size_i);
    // Clearing the low log2(bytes) bits forces misaligned requests to natural alignment.
    offset    = offset_i & ~(bytes[2:0] - 3'd1);
    byte_ones = 8'hFF >> (4'd8 - bytes);
    mask_o    = byte_ones << offset;
    byte_sel  = '0;
    for (int b = 0; b < 8; b++) begin
      byte_sel[8*b +: 8] = {8{byte_ones[b]}};
    end
    wdata_o     = wdata_i << {offset, 3'b000};
    rdata_shift = (rdata_i >> {offset, 3'b000}) & byte_sel;
    rdata_o     = {{(cce_block_width_p-dword_width_gp){1'b0}}, rdata_shift};
  end

endmodule

// File: rtl/bp_io_responder.sv
// rtl/bp_io_responder.sv - uncached IO endpoint, one dword access per command; BP_IO_RESPONDER_TIMEOUT_EN adds a read-wait timeout
module bp_io_responder
  import bp_me_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_inv_cfg,
  parameter int timeout_cycles_p = 1024,
  localparam bp_cfg_s cfg_lp = bp_get_cfg(bp_params_p),
  localparam int paddr_width_p = cfg_lp.paddr_width,
  localparam int dword_width_p = cfg_lp.dword_width,
  localparam int cce_block_width_p = cfg_lp.cce_block_width,
  localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
  input  logic                            io_cmd_v_i,
  output logic                            io_cmd_yumi_o,
  output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
  output logic                            io_resp_v_o,
  input  logic                            io_resp_ready_i,
  output logic                            dev_v_o,
  output logic                            dev_w_o,
  output logic [paddr_width_p-1:0]        dev_addr_o,
  output logic [dword_width_p-1:0]        dev_data_o,
  output logic [dword_width_p/8-1:0]      dev_mask_o,
  input  logic                            dev_ready_i,
  input  logic [dword_width_p-1:0]        dev_data_i,
  input  logic                            dev_v_i
);

  bp_cce_mem_msg_s cmd;
  bp_cce_mem_msg_s resp;
  assign cmd = bp_cce_mem_msg_s'(io_cmd_i);

  logic unused_cmd_data;
  assign unused_cmd_data = ^cmd.data[cce_block_width_p-1:dword_width_p];

  bp_io_responder_state_e         state_q, state_d;
  bp_cce_mem_msg_header_s         hdr_q, hdr_d;
  logic [dword_width_p-1:0]       wdata_q, wdata_d;
  logic [cce_block_width_p-1:0]   rdata_q, rdata_d;

  logic                           is_wr;
  logic                           timeout;
  logic [dword_width_p-1:0]       lane_rdata_in;
  logic [dword_width_p/8-1:0]     lane_mask;
  logic [dword_width_p-1:0]       lane_wdata;
  logic [cce_block_width_p-1:0]   lane_rdata;

  assign is_wr = (hdr_q.msg_type == e_cce_mem_uc_wr);

`ifdef BP_IO_RESPONDER_TIMEOUT_EN
  localparam int cnt_width_lp = $clog2(timeout_cycles_p + 1);
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;

  // Count is zero whenever we are outside e_dev_wait, so entry always starts from zero.
  assign timeout       = (state_q == e_dev_wait) && (cnt_q == cnt_width_lp'(timeout_cycles_p - 1));
  assign lane_rdata_in = timeout ? '1 : dev_data_i;

  always_comb begin
    cnt_d = '0;
    if (state_q == e_dev_wait) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end
`else
  assign timeout       = 1'b0;
  assign lane_rdata_in = dev_data_i;
`endif

  bp_io_lane_align #(.cce_block_width_p(cce_block_width_p)) u_lane_align (
    .size_i   (hdr_q.size),
    .offset_i (hdr_q.addr[2:0]),
    .wdata_i  (wdata_q),
    .rdata_i  (lane_rdata_in),
    .mask_o   (lane_mask),
    .wdata_o  (lane_wdata),
    .rdata_o  (lane_rdata)
  );

  always_comb begin
    state_d       = state_q;
    hdr_d         = hdr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    io_cmd_yumi_o = 1'b0;
    io_resp_v_o   = 1'b0;
    dev_v_o       = 1'b0;
    case (state_q)
      e_ready: begin
        io_cmd_yumi_o = io_cmd_v_i;
        if (io_cmd_v_i) begin
          hdr_d   = cmd.header;
          wdata_d = cmd.data[dword_width_p-1:0];
          rdata_d = '0;
          state_d = e_dev_req;
        end
      end
      e_dev_req: begin
        dev_v_o = 1'b1;
        if (dev_ready_i) state_d = is_wr ? e_resp : e_dev_wait;
      end
      e_dev_wait: begin
        if (dev_v_i || timeout) begin
          rdata_d = lane_rdata;
          state_d = e_resp;
        end
      end
      e_resp: begin
        io_resp_v_o = 1'b1;
        if (io_resp_ready_i) state_d = e_ready;
      end
      default: state_d = e_ready;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_ready;
      hdr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Device fields are only driven during the request so they read as zero when idle.
  assign dev_w_o    = dev_v_o & is_wr;
  assign dev_addr_o = dev_v_o ? {hdr_q.addr[paddr_width_p-1:3], 3'b000} : '0;
  assign dev_data_o = dev_v_o ? lane_wdata : '0;
  assign dev_mask_o = dev_v_o ? lane_mask : '0;

  assign resp.header = hdr_q;
  assign resp.data   = rdata_q;
  assign io_resp_o   = resp;

endmodule

// File: tb/tb_bp_io_responder.sv
// tb/tb_bp_io_responder.sv - scoreboard bench for bp_io_responder
module tb_bp_io_responder;
  import bp_me_pkg::*;

  localparam int W = $bits(bp_cce_mem_msg_s);

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [W-1:0]  io_cmd_i;
  logic          io_cmd_v_i;
  logic          io_cmd_yumi_o;
  logic [W-1:0]  io_resp_o;
  logic          io_resp_v_o;
  logic          io_resp_ready_i;
  logic          dev_v_o;
  logic          dev_w_o;
  logic [39:0]   dev_addr_o;
  logic [63:0]   dev_data_o;
  logic [7:0]    dev_mask_o;
  logic          dev_ready_i;
  logic [63:0]   dev_data_i;
  logic          dev_v_i;

  always #5 clk_i = ~clk_i;

  bp_io_responder #(.timeout_cycles_p(16)) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .io_cmd_i        (io_cmd_i),
    .io_cmd_v_i      (io_cmd_v_i),
    .io_cmd_yumi_o   (io_cmd_yumi_o),
    .io_resp_o       (io_resp_o),
    .io_resp_v_o     (io_resp_v_o),
    .io_resp_ready_i (io_resp_ready_i),
    .dev_v_o         (dev_v_o),
    .dev_w_o         (dev_w_o),
    .dev_addr_o      (dev_addr_o),
    .dev_data_o      (dev_data_o),
    .dev_mask_o      (dev_mask_o),
    .dev_ready_i     (dev_ready_i),
    .dev_data_i      (dev_data_i),
    .dev_v_i         (dev_v_i)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bp_cce_mem_msg_s exp_q[$];

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_bytes(input bp_mem_size_e s);
    case (s)
      e_mem_size_1: return 1;
      e_mem_size_2: return 2;
      e_mem_size_4: return 4;
      default:      return 8;
    endcase
  endfunction

  function automatic int m_off(input bp_cce_mem_msg_s m);
    int n = m_bytes(m.header.size);
    return (int'(m.header.addr[2:0]) / n) * n;
  endfunction

  function automatic logic [7:0] m_mask(input bp_cce_mem_msg_s m);
    int n = m_bytes(m.header.size);
    int o = m_off(m);
    logic [7:0] r = '0;
    for (int b = 0; b < 8; b++) r[b] = (b >= o) && (b < o + n);
    return r;
  endfunction

  function automatic logic [63:0] m_wdata(input bp_cce_mem_msg_s m);
    int o = m_off(m);
    logic [63:0] r = '0;
    for (int b = 0; b < 8; b++) if (b >= o) r[8*b +: 8] = m.data[8*(b-o) +: 8];
    return r;
  endfunction

  function automatic bp_cce_mem_msg_s m_resp(input bp_cce_mem_msg_s m, input logic [63:0] rd);
    bp_cce_mem_msg_s r = m;
    int n = m_bytes(m.header.size);
    int o = m_off(m);
    r.data = '0;
    if (m.header.msg_type != e_cce_mem_uc_wr)
      for (int i = 0; i < n; i++) r.data[8*i +: 8] = rd[8*(o+i) +: 8];
    return r;
  endfunction

  function automatic bp_cce_mem_msg_s mk(input bp_cce_mem_cmd_type_e t, input bp_mem_size_e s,
                                          input logic [39:0] a, input logic [63:0] d, input logic [3:0] lce);
    bp_cce_mem_msg_s m = '0;
    m.header.msg_type       = t;
    m.header.size           = s;
    m.header.addr           = a;
    m.header.payload.lce_id = lce;
    m.header.payload.way_id = 3'd5;
    m.data                  = {{7{64'hA5A5_5A5A_0F0F_F0F0}}, d};
    return m;
  endfunction

  always @(negedge clk_i) begin
    if (reset_n_i === 1'b1 && io_resp_v_o && io_resp_ready_i) begin
      if (exp_q.size() == 0) check_eq("resp_unexpected", 1, 0);
      else                   check_eq("resp_msg", io_resp_o, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input bp_cce_mem_msg_s m, input logic [63:0] rd);
    int n = 0;
    io_cmd_i   = m;
    io_cmd_v_i = 1'b1;
    @(negedge clk_i);
    while (!io_cmd_yumi_o && n < 20) begin
      tick();
      @(negedge clk_i);
      n++;
    end
    check_eq("cmd_yumi", io_cmd_yumi_o, 1);
    exp_q.push_back(m_resp(m, rd));
    tick();
    io_cmd_v_i = 1'b0;
  endtask

  task automatic dev_phase(input bp_cce_mem_msg_s m, input int ready_wait, input int ret_wait,
                           input logic [63:0] rd, input logic [7:0] exp_mask);
    logic wr = (m.header.msg_type == e_cce_mem_uc_wr);
    for (int i = 0; i <= ready_wait; i++) begin
      dev_ready_i = (i == ready_wait);
      @(negedge clk_i);
      check_eq("dev_v", dev_v_o, 1);
      check_eq("dev_w", dev_w_o, wr);
      check_eq("dev_addr", dev_addr_o, {m.header.addr[39:3], 3'b000});
      check_eq("dev_mask", dev_mask_o, exp_mask);
      if (wr) check_eq("dev_data", dev_data_o, m_wdata(m));
      tick();
    end
    dev_ready_i = 1'b0;
    if (!wr) begin
      repeat (ret_wait) tick();
      dev_v_i    = 1'b1;
      dev_data_i = rd;
      tick();
      dev_v_i    = 1'b0;
      dev_data_i = {$urandom, $urandom};
    end
  endtask

  task automatic resp_phase(input int hold, input bit pend, input logic [63:0] exp_data);
    bp_cce_mem_msg_s rv;
    for (int i = 0; i <= hold; i++) begin
      io_resp_ready_i = (i == hold);
      @(negedge clk_i);
      rv = io_resp_o;
      if (i == 0) begin
        check_eq("resp_v", io_resp_v_o, 1);
        check_eq("resp_data", rv.data[63:0], exp_data);
      end
      if (i < hold) begin
        check_eq("resp_stable", io_resp_o, (exp_q.size() > 0) ? exp_q[0] : '0);
        if (pend) check_eq("no_yumi_pending", io_cmd_yumi_o, 0);
      end
      tick();
    end
    io_resp_ready_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_yumi"}, io_cmd_yumi_o, 0);
    check_eq({tag, "_resp_v"}, io_resp_v_o, 0);
    check_eq({tag, "_dev_v"}, dev_v_o, 0);
    check_eq({tag, "_dev_w"}, dev_w_o, 0);
    check_eq({tag, "_dev_addr"}, dev_addr_o, 0);
    check_eq({tag, "_dev_data"}, dev_data_o, 0);
    check_eq({tag, "_dev_mask"}, dev_mask_o, 0);
    check_eq({tag, "_resp"}, io_resp_o, 0);
  endtask

  initial begin
    bp_cce_mem_msg_s m, m2;
    logic [63:0] rd;
    int n;

    reset_n_i = 1'b0;
    io_cmd_i = '0; io_cmd_v_i = 1'b0; io_resp_ready_i = 1'b0;
    dev_ready_i = 1'b0; dev_data_i = '0; dev_v_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    tick();

    // Write with device stall, then response back-pressure with a second command pending.
    m = mk(e_cce_mem_uc_wr, e_mem_size_4, 40'h1004, 64'hDEAD_BEEF, 4'd2);
    issue(m, 64'h0);
    @(negedge clk_i);
    check_eq("wr_addr_const", dev_addr_o, 40'h1000);
    check_eq("wr_mask_const", dev_mask_o, 8'hF0);
    check_eq("wr_data_const", dev_data_o, 64'hDEAD_BEEF_0000_0000);
    check_eq("wr_w_const", dev_w_o, 1);
    tick();
    dev_phase(m, 5, 0, 64'h0, 8'hF0);
    rd = 64'h8877_6655_4433_2211;
    m2 = mk(e_cce_mem_uc_rd, e_mem_size_1, 40'h2003, 64'h1234, 4'd7);
    io_cmd_i = m2; io_cmd_v_i = 1'b1;
    dev_v_i = 1'b1; dev_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    dev_v_i = 1'b0;
    resp_phase(10, 1'b1, 64'h0);
    @(negedge clk_i);
    check_eq("yumi_after_release", io_cmd_yumi_o, 1);
    exp_q.push_back(m_resp(m2, rd));
    tick();
    io_cmd_v_i = 1'b0;
    dev_phase(m2, 0, 0, rd, 8'h08);
    resp_phase(0, 1'b0, 64'h44);

    // Misaligned halfword read is forced to natural alignment.
    m = mk(e_cce_mem_uc_rd, e_mem_size_2, 40'h2003, 64'h0, 4'd1);
    issue(m, rd);
    dev_phase(m, 1, 2, rd, 8'h0C);
    resp_phase(0, 1'b0, 64'h4433);

    m = mk(e_cce_mem_uc_rd, e_mem_size_8, 40'h3005, 64'h0, 4'd3);
    issue(m, 64'h0123_4567_89AB_CDEF);
    dev_phase(m, 0, 1, 64'h0123_4567_89AB_CDEF, 8'hFF);
    resp_phase(1, 1'b0, 64'h0123_4567_89AB_CDEF);

    m = mk(e_cce_mem_uc_wr, e_mem_size_1, 40'h0007, 64'h0000_0000_0000_00AB, 4'd4);
    issue(m, 64'h0);
    dev_phase(m, 0, 0, 64'h0, 8'h80);
    resp_phase(0, 1'b0, 64'h0);

    for (int t = 0; t < 8; t++) begin
      bp_cce_mem_cmd_type_e ty;
      case ($urandom_range(0, 2))
        0:       ty = e_cce_mem_uc_rd;
        1:       ty = e_cce_mem_uc_wr;
        default: ty = e_cce_mem_rd;
      endcase
      m  = mk(ty, bp_mem_size_e'($urandom_range(0, 3)), {$urandom, 8'($urandom)},
              {$urandom, $urandom}, 4'($urandom));
      rd = {$urandom, $urandom};
      issue(m, rd);
      dev_phase(m, $urandom_range(0, 3), $urandom_range(0, 3), rd, m_mask(m));
      resp_phase($urandom_range(0, 2), 1'b0, m_resp(m, rd).data[63:0]);
    end

`ifdef BP_IO_RESPONDER_TIMEOUT_EN
    m = mk(e_cce_mem_uc_rd, e_mem_size_4, 40'h4004, 64'h0, 4'd6);
    issue(m, 64'hFFFF_FFFF_FFFF_FFFF);
    dev_ready_i = 1'b1;
    tick();
    dev_ready_i = 1'b0;
    n = 0;
    @(negedge clk_i);
    while (!io_resp_v_o && n < 100) begin
      tick();
      @(negedge clk_i);
      n++;
    end
    check_eq("timeout_cycles", n, 16);
    tick();
    dev_v_i = 1'b1; dev_data_i = 64'h0;
    tick();
    dev_v_i = 1'b0;
    resp_phase(0, 1'b0, 64'hFFFF_FFFF);
`endif

    // Reset while waiting on the device drops the transaction.
    m = mk(e_cce_mem_uc_rd, e_mem_size_4, 40'h5008, 64'h0, 4'd5);
    issue(m, 64'h0);
    dev_ready_i = 1'b1;
    tick();
    dev_ready_i = 1'b0;
    tick();
    #2 reset_n_i = 1'b0;
    #1;
    check_all_zero("midreset");
    void'(exp_q.pop_back());
    repeat (2) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    dev_v_i = 1'b1; dev_data_i = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    dev_v_i = 1'b0;
    @(negedge clk_i);
    check_eq("no_stale_resp", io_resp_v_o, 0);
    tick();

    rd = 64'hCAFE_F00D_1357_9BDF;
    m = mk(e_cce_mem_uc_rd, e_mem_size_4, 40'h5004, 64'h0, 4'd5);
    issue(m, rd);
    dev_phase(m, 0, 0, rd, 8'hF0);
    resp_phase(0, 1'b0, 64'hCAFE_F00D);

    repeat (3) tick();
    check_eq("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
